// File: rtl/stack_isa_pkg.sv
// Shared ISA encodings for the 16-bit stack processor: opcodes, datapath control codes,
// fault codes and the fetch/control FSM state type.
package stack_isa_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_PUSHI = 4'h1;
    localparam logic [3:0] OP_ADD   = 4'h2;
    localparam logic [3:0] OP_SUB   = 4'h3;
    localparam logic [3:0] OP_OR    = 4'h4;
    localparam logic [3:0] OP_SLT   = 4'h5;
    localparam logic [3:0] OP_DUP   = 4'h6;
    localparam logic [3:0] OP_OVER  = 4'h7;
    localparam logic [3:0] OP_DROP  = 4'h8;
    localparam logic [3:0] OP_SWAP  = 4'h9;
    localparam logic [3:0] OP_BEQ   = 4'hA;
    localparam logic [3:0] OP_BEZ   = 4'hB;
    localparam logic [3:0] OP_JMP   = 4'hC;
    localparam logic [3:0] OP_PUSHS = 4'hD;
    localparam logic [3:0] OP_ILL   = 4'hE;
    localparam logic [3:0] OP_HALT  = 4'hF;

    // Stack and ALU codes must match the stack datapath decoding.
    localparam logic [2:0] STK_HOLD = 3'd0;
    localparam logic [2:0] STK_PUSH = 3'd1;
    localparam logic [2:0] STK_POP2 = 3'd2;
    localparam logic [2:0] STK_DROP = 3'd3;
    localparam logic [2:0] STK_CMP  = 3'd4;
    localparam logic [2:0] STK_SWAP = 3'd5;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_DUP  = 4'd5;
    localparam logic [3:0] ALU_OVER = 4'd6;
    localparam logic [3:0] ALU_BEQ  = 4'd7;
    localparam logic [3:0] ALU_BEZ  = 4'd8;
    localparam logic [3:0] ALU_SLT  = 4'd9;

    localparam logic [2:0] MUX_ALU  = 3'd0;
    localparam logic [2:0] MUX_IMM  = 3'd1;

    localparam logic [1:0] FLT_NONE    = 2'd0;
    localparam logic [1:0] FLT_ILLEGAL = 2'd1;
    localparam logic [1:0] FLT_OVF     = 2'd2;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_FETCH_IMM,
        ST_EXEC,
        ST_BRANCH,
        ST_HALT
    } fsm_state_t;

endpackage

// File: rtl/stack_fetch_decode_if.sv
// Instruction-memory req/ack bus between the fetch unit (master) and instruction memory (slave).
interface stack_fetch_decode_if #(
    parameter int PC_WIDTH   = 12,
    parameter int DATA_WIDTH = 16
);
    logic                  imem_req;
    logic [PC_WIDTH-1:0]   imem_addr;
    logic                  imem_ack;
    logic [DATA_WIDTH-1:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/stack_insn_decode.sv
// Pure combinational opcode decode into datapath controls and instruction-class flags.
module stack_insn_decode
    import stack_isa_pkg::*;
(
    input  logic [3:0] opcode,
    output logic [2:0] stack_op,
    output logic [3:0] alu_op,
    output logic [2:0] mux_sel,
    output logic       is_branch,
    output logic       is_two_word,
    output logic       illegal
);

    always_comb begin
        stack_op    = STK_HOLD;
        alu_op      = ALU_ADD;
        mux_sel     = MUX_ALU;
        is_branch   = 1'b0;
        is_two_word = 1'b0;
        illegal     = 1'b0;
        case (opcode)
            OP_PUSHI: begin
                stack_op    = STK_PUSH;
                mux_sel     = MUX_IMM;
                is_two_word = 1'b1;
            end
            OP_ADD:   stack_op = STK_POP2;
            OP_SUB:   begin stack_op = STK_POP2; alu_op = ALU_SUB;  end
            OP_OR:    begin stack_op = STK_POP2; alu_op = ALU_OR;   end
            OP_SLT:   begin stack_op = STK_POP2; alu_op = ALU_SLT;  end
            OP_DUP:   begin stack_op = STK_PUSH; alu_op = ALU_DUP;  end
            OP_OVER:  begin stack_op = STK_PUSH; alu_op = ALU_OVER; end
            OP_DROP:  stack_op = STK_DROP;
            OP_SWAP:  stack_op = STK_SWAP;
            OP_BEQ:   begin stack_op = STK_CMP; alu_op = ALU_BEQ; is_branch = 1'b1; end
            OP_BEZ:   begin stack_op = STK_CMP; alu_op = ALU_BEZ; is_branch = 1'b1; end
            OP_PUSHS: begin stack_op = STK_PUSH; mux_sel = MUX_IMM; end
            OP_ILL:   illegal = 1'b1;
            default:  ;
        endcase
    end

endmodule

// File: rtl/stack_fetch_decode.sv
// Fetch/control unit: fetches over a req/ack bus, holds pc/IR/immediate and sequences one
// control pulse per instruction towards the stack datapath.
//
//   state        | meaning
//   ST_FETCH     | request word at pc, load IR on ack
//   ST_DECODE    | classify IR, pick next state (JMP/NOP resolve here)
//   ST_FETCH_IMM | request PUSHI immediate word
//   ST_EXEC      | one-cycle datapath control pulse
//   ST_BRANCH    | one-cycle compare pulse, resolve on ALU_out[0]
//   ST_HALT      | stopped until reset
module stack_fetch_decode
    import stack_isa_pkg::*;
#(
    parameter int PC_WIDTH    = 12,
    parameter int DATA_WIDTH  = 16,
    parameter bit HALT_ON_OVF = 1'b1
) (
    input  logic                  CLK,
    input  logic                  reset,
    stack_fetch_decode_if.master  imem,
    input  logic [15:0]           ALU_out,
    input  logic                  Overflow,
    output logic [2:0]            stackOP,
    output logic [3:0]            aluOP,
    output logic [2:0]            mux_selector,
    output logic [DATA_WIDTH-1:0] immediate,
    output logic [PC_WIDTH-1:0]   pc,
    output logic                  halted,
    output logic [1:0]            fault
);

    fsm_state_t            state, state_nxt;
    logic [PC_WIDTH-1:0]   pc_q, pc_nxt;
    logic [DATA_WIDTH-1:0] ir_q, ir_nxt;
    logic [DATA_WIDTH-1:0] imm_q, imm_nxt;
    logic [1:0]            fault_q, fault_nxt;
    logic                  req;

    logic [3:0]            opcode;
    logic [PC_WIDTH-1:0]   target;
    logic [2:0]            dec_stack_op;
    logic [3:0]            dec_alu_op;
    logic [2:0]            dec_mux_sel;
    logic                  dec_is_branch;
    logic                  dec_is_two_word;
    logic                  dec_illegal;
    logic                  unused_alu_bits;

    assign opcode          = ir_q[15:12];
    assign target          = PC_WIDTH'(ir_q[11:0]);
    assign unused_alu_bits = ^ALU_out[15:1];

    stack_insn_decode u_decode (
        .opcode      (opcode),
        .stack_op    (dec_stack_op),
        .alu_op      (dec_alu_op),
        .mux_sel     (dec_mux_sel),
        .is_branch   (dec_is_branch),
        .is_two_word (dec_is_two_word),
        .illegal     (dec_illegal)
    );

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state   <= ST_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            imm_q   <= '0;
            fault_q <= FLT_NONE;
        end else begin
            state   <= state_nxt;
            pc_q    <= pc_nxt;
            ir_q    <= ir_nxt;
            imm_q   <= imm_nxt;
            fault_q <= fault_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc_q;
        ir_nxt       = ir_q;
        imm_nxt      = imm_q;
        fault_nxt    = fault_q;
        req          = 1'b0;
        stackOP      = STK_HOLD;
        aluOP        = ALU_ADD;
        mux_selector = MUX_ALU;
        immediate    = '0;
        case (state)
            ST_FETCH: begin
                req = 1'b1;
                if (imem.imem_ack) begin
                    ir_nxt    = imem.imem_rdata;
                    pc_nxt    = pc_q + PC_WIDTH'(1);
                    state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (dec_illegal) begin
                    fault_nxt = FLT_ILLEGAL;
                    state_nxt = ST_HALT;
                end else if (opcode == OP_HALT) begin
                    state_nxt = ST_HALT;
                end else if (dec_is_two_word) begin
                    state_nxt = ST_FETCH_IMM;
                end else if (dec_is_branch) begin
                    state_nxt = ST_BRANCH;
                end else if (opcode == OP_JMP) begin
                    pc_nxt    = target;
                    state_nxt = ST_FETCH;
                end else if (opcode == OP_NOP) begin
                    state_nxt = ST_FETCH;
                end else begin
                    state_nxt = ST_EXEC;
                end
            end
            ST_FETCH_IMM: begin
                req = 1'b1;
                if (imem.imem_ack) begin
                    imm_nxt   = imem.imem_rdata;
                    pc_nxt    = pc_q + PC_WIDTH'(1);
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                stackOP      = dec_stack_op;
                aluOP        = dec_alu_op;
                mux_selector = dec_mux_sel;
                if (opcode == OP_PUSHI)
                    immediate = imm_q;
                else if (opcode == OP_PUSHS)
                    immediate = DATA_WIDTH'($signed(ir_q[11:0]));
                // Overflow is judged at the same edge that commits the stack result.
                if (HALT_ON_OVF && Overflow && (opcode == OP_ADD || opcode == OP_SUB)) begin
                    fault_nxt = FLT_OVF;
                    state_nxt = ST_HALT;
                end else begin
                    state_nxt = ST_FETCH;
                end
            end
            ST_BRANCH: begin
                stackOP = dec_stack_op;
                aluOP   = dec_alu_op;
                if (ALU_out[0])
                    pc_nxt = target;
                state_nxt = ST_FETCH;
            end
            ST_HALT: ;
            default: state_nxt = ST_FETCH;
        endcase
    end

    // Reset parks the FSM in FETCH, so the request must be masked while reset is held.
    assign imem.imem_req  = req & reset;
    assign imem.imem_addr = pc_q;
    assign pc             = pc_q;
    assign halted         = (state == ST_HALT);
    assign fault          = fault_q;

endmodule

// File: tb/tb_stack_fetch_decode.sv
// Self-checking bench: ISA-level interpreter predicts fetch addresses, control pulses and halt state.
module tb_stack_fetch_decode;

    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] ALU_out;
    logic        Overflow;
    logic [2:0]  stackOP;
    logic [3:0]  aluOP;
    logic [2:0]  mux_selector;
    logic [15:0] immediate;
    logic [11:0] pc;
    logic        halted;
    logic [1:0]  fault;

    stack_fetch_decode_if #(.PC_WIDTH(12), .DATA_WIDTH(16)) bus ();

    stack_fetch_decode #(.PC_WIDTH(12), .DATA_WIDTH(16), .HALT_ON_OVF(1'b1)) dut (
        .CLK          (CLK),
        .reset        (reset),
        .imem         (bus),
        .ALU_out      (ALU_out),
        .Overflow     (Overflow),
        .stackOP      (stackOP),
        .aluOP        (aluOP),
        .mux_selector (mux_selector),
        .immediate    (immediate),
        .pc           (pc),
        .halted       (halted),
        .fault        (fault)
    );

    always #5 CLK = ~CLK;

    logic [15:0] mem [4096];
    bit          taken [512];
    int          errors = 0;
    int          checks = 0;

    logic [11:0] exp_fetch [$];
    logic [25:0] exp_pulse [$];
    logic [11:0] exp_pc;
    logic [1:0]  exp_fault;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [25:0] pk(input int s, input int a, input int m, input logic [15:0] i);
        return {3'(s), 4'(a), 3'(m), i};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    endtask

    // Instruction-level interpreter: one step per instruction, no cycle timing.
    task automatic build_model(input bit ovf);
        logic [11:0] mpc;
        logic [15:0] w;
        int          fidx;
        bit          done;
        int          bin_alu [4] = '{0, 1, 3, 9};
        exp_fetch.delete();
        exp_pulse.delete();
        mpc = 12'h000; fidx = 0; done = 1'b0; exp_fault = 2'd0;
        for (int step = 0; step < 300 && !done; step++) begin
            exp_fetch.push_back(mpc);
            w = mem[mpc]; mpc = mpc + 12'd1; fidx++;
            case (w[15:12])
                4'h0: ;
                4'h1: begin
                    exp_fetch.push_back(mpc);
                    exp_pulse.push_back(pk(1, 0, 1, mem[mpc]));
                    mpc = mpc + 12'd1; fidx++;
                end
                4'h2, 4'h3, 4'h4, 4'h5: begin
                    exp_pulse.push_back(pk(2, bin_alu[int'(w[15:12]) - 2], 0, 16'h0));
                    if (ovf && (w[15:12] == 4'h2 || w[15:12] == 4'h3)) begin
                        exp_fault = 2'd2; done = 1'b1;
                    end
                end
                4'h6: exp_pulse.push_back(pk(1, 5, 0, 16'h0));
                4'h7: exp_pulse.push_back(pk(1, 6, 0, 16'h0));
                4'h8: exp_pulse.push_back(pk(3, 0, 0, 16'h0));
                4'h9: exp_pulse.push_back(pk(5, 0, 0, 16'h0));
                4'hA, 4'hB: begin
                    exp_pulse.push_back(pk(4, (w[15:12] == 4'hA) ? 7 : 8, 0, 16'h0));
                    if (taken[fidx-1]) mpc = w[11:0];
                end
                4'hC: mpc = w[11:0];
                4'hD: exp_pulse.push_back(pk(1, 0, 1, {{4{w[11]}}, w[11:0]}));
                4'hE: begin exp_fault = 2'd1; done = 1'b1; end
                default: done = 1'b1;
            endcase
        end
        exp_pc = mpc;
    endtask

    // fixed_wait < 0 draws 0..3 wait cycles per fetch.
    task automatic run_prog(input string name, input int fixed_wait, input bit ovf);
        int          fi, pi, wait_left;
        logic [25:0] obs_p;
        build_model(ovf);
        Overflow = ovf;
        bus.imem_ack = 1'b0; bus.imem_rdata = 16'h0; ALU_out = 16'h0;
        reset = 1'b0;
        repeat (2) @(negedge CLK);
        check({name, ":reset_outs"}, {bus.imem_req, bus.imem_addr, pc, stackOP, aluOP,
              mux_selector, immediate, halted, fault}, 64'h0);
        reset = 1'b1;
        fi = 0; pi = 0;
        wait_left = (fixed_wait < 0) ? int'($urandom_range(0, 3)) : fixed_wait;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            #1;
            if (halted) break;
            obs_p = {stackOP, aluOP, mux_selector, immediate};
            if (obs_p != 26'h0) begin
                if (pi < exp_pulse.size()) check({name, ":pulse"}, obs_p, exp_pulse[pi]);
                else check({name, ":extra_pulse"}, obs_p, 26'h0);
                pi++;
            end
            if (bus.imem_req) begin
                if (fi >= exp_fetch.size()) begin
                    check({name, ":fetch_count"}, fi, exp_fetch.size() - 1);
                    break;
                end
                check({name, ":addr"}, bus.imem_addr, exp_fetch[fi]);
                if (wait_left == 0) begin
                    bus.imem_ack   = 1'b1;
                    bus.imem_rdata = mem[bus.imem_addr];
                    ALU_out        = {15'h0, taken[fi]};
                    fi++;
                    wait_left = (fixed_wait < 0) ? int'($urandom_range(0, 3)) : fixed_wait;
                end else begin
                    bus.imem_ack = 1'b0;
                    wait_left--;
                end
            end else begin
                bus.imem_ack   = 1'($urandom_range(0, 1));
                bus.imem_rdata = 16'($urandom);
            end
            @(negedge CLK);
        end
        check({name, ":halted"}, halted, 1'b1);
        check({name, ":fetches"}, fi, exp_fetch.size());
        check({name, ":pulses"}, pi, exp_pulse.size());
        check({name, ":pc"}, pc, exp_pc);
        check({name, ":fault"}, fault, exp_fault);
        for (int k = 0; k < 4; k++) begin
            bus.imem_ack = 1'b1;
            bus.imem_rdata = 16'($urandom);
            @(negedge CLK); #1;
            check({name, ":halt_quiet"}, {bus.imem_req, stackOP, aluOP, mux_selector, immediate}, 27'h0);
        end
        check({name, ":halt_pc_hold"}, pc, exp_pc);
        bus.imem_ack = 1'b0;
    endtask

    task automatic gen_random();
        int          n;
        logic [3:0]  ops  [40];
        logic [11:0] addr [41];
        logic [11:0] a;
        logic [11:0] field;
        clear_mem();
        n = $urandom_range(15, 35);
        a = 12'h000;
        for (int i = 0; i < n; i++) begin
            ops[i]  = 4'($urandom_range(0, 13));
            addr[i] = a;
            a = a + ((ops[i] == 4'h1) ? 12'd2 : 12'd1);
        end
        addr[n] = a;
        mem[a]  = 16'hF000;
        for (int i = 0; i < n; i++) begin
            field = 12'($urandom);
            if (ops[i] == 4'hA || ops[i] == 4'hB || ops[i] == 4'hC)
                field = addr[$urandom_range(i + 1, n)];
            mem[addr[i]] = {ops[i], field};
            if (ops[i] == 4'h1) mem[addr[i] + 12'd1] = 16'($urandom);
        end
        for (int k = 0; k < 512; k++) taken[k] = 1'($urandom_range(0, 1));
    endtask

    initial begin
        Overflow = 1'b0; ALU_out = 16'h0;
        bus.imem_ack = 1'b0; bus.imem_rdata = 16'h0;
        for (int k = 0; k < 512; k++) taken[k] = 1'b0;

        clear_mem();
        mem[0] = 16'h1000; mem[1] = 16'h0005; mem[2] = 16'hD003; mem[3] = 16'h2000; mem[4] = 16'hF000;
        run_prog("push_add", 0, 1'b0);
        run_prog("push_add_wait3", 3, 1'b0);

        clear_mem();
        mem[0] = 16'hD001; mem[1] = 16'hD001; mem[2] = 16'hA008; mem[3] = 16'hF000; mem[8] = 16'hF000;
        for (int k = 0; k < 512; k++) taken[k] = 1'b1;
        run_prog("beq_taken", 0, 1'b0);
        for (int k = 0; k < 512; k++) taken[k] = 1'b0;
        run_prog("beq_not_taken", 0, 1'b0);

        clear_mem();
        mem[0] = 16'hA005; mem[1] = 16'hC7FF; mem[12'h7FF] = 16'hDFFF;
        mem[12'h800] = 16'hCFFF; mem[12'hFFF] = 16'h0000; mem[5] = 16'hF000;
        for (int k = 0; k < 512; k++) taken[k] = 1'b1;
        taken[0] = 1'b0;
        run_prog("jmp_wrap", -1, 1'b0);

        clear_mem();
        mem[0] = 16'hE000;
        run_prog("illegal", 0, 1'b0);
        mem[0] = 16'hF000;
        run_prog("halt", 0, 1'b0);

        clear_mem();
        mem[0] = 16'hD001; mem[1] = 16'hD001; mem[2] = 16'h2000; mem[3] = 16'hF000;
        run_prog("add_ovf", -1, 1'b1);

        // Reset pulse while the PUSHI immediate fetch is waiting.
        clear_mem();
        mem[0] = 16'h1000; mem[1] = 16'h0005; mem[2] = 16'hF000;
        Overflow = 1'b0;
        bus.imem_ack = 1'b0;
        reset = 1'b0;
        @(negedge CLK);
        reset = 1'b1;
        #1;
        bus.imem_ack = 1'b1; bus.imem_rdata = mem[0];
        @(negedge CLK); #1;
        bus.imem_ack = 1'b0;
        @(negedge CLK); #1;
        check("midrst:imm_req", {bus.imem_req, bus.imem_addr}, {1'b1, 12'h001});
        @(negedge CLK); #2;
        reset = 1'b0;
        #1;
        check("midrst:outs", {bus.imem_req, bus.imem_addr, pc, stackOP, aluOP,
              mux_selector, immediate, halted, fault}, 64'h0);
        bus.imem_ack = 1'b1; bus.imem_rdata = 16'h0005;
        @(negedge CLK);
        check("midrst:late_ack_pc", pc, 12'h000);
        bus.imem_ack = 1'b0;
        reset = 1'b1;
        #1;
        check("midrst:restart", {bus.imem_req, bus.imem_addr}, {1'b1, 12'h000});
        run_prog("midrst:rerun", 0, 1'b0);

        for (int r = 0; r < 8; r++) begin
            gen_random();
            run_prog($sformatf("random%0d", r), -1, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stack_fetch_decode.md
# stack_fetch_decode

Instruction fetch and control unit for the 16-bit stack processor. It sits directly upstream of the push/pop stack-ALU integration. It fetches instruction words from instruction memory over a req/ack handshake and decodes each one into `stackOP`, `aluOP`, `mux_selector` and `immediate` for one cycle. It also resolves branches from the datapath's `ALU_out`.

## Interface
- `PC_WIDTH`, 12: instruction address width.
- `DATA_WIDTH`, 16: instruction/immediate width.
- `HALT_ON_OVF`, 1: when 1, an `Overflow` seen on an executing ADD/SUB halts the core.

Ports:
- `CLK` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low.
- `imem_req` out 1: fetch request.
- `imem_addr` out PC_WIDTH: fetch address; stable while `imem_req`=1.
- `imem_ack` in 1: fetch complete; `imem_rdata` is valid in the same cycle.
- `imem_rdata` in DATA_WIDTH: fetched word.
- `ALU_out` in 16: datapath ALU result; branch condition is bit 0 (1 = taken).
- `Overflow` in 1: datapath overflow flag.
- `stackOP` out 3: 0 hold, 1 push, 2 binary-pop, 3 drop, 4 compare (no stack change), 5 swap.
- `aluOP` out 4: 0 add, 1 sub, 3 or, 5 dup, 6 over, 7 beq, 8 bez, 9 slt.
- `mux_selector` out 3: 0 selects ALU, 1 selects immediate.
- `immediate` out DATA_WIDTH: push value.
- `pc` out PC_WIDTH: current program counter.
- `halted` out 1: core stopped.
- `fault` out 2: 0 none, 1 illegal opcode, 2 overflow trap.

## Operation
- Instruction format: opcode in [15:12], field in [11:0].
- Opcodes:
  - 0 NOP
  - 1 PUSHI: two words; the second word is the 16-bit immediate.
  - 2 ADD, 3 SUB, 4 OR, 5 SLT: stackOP=2 with aluOP 0/1/3/9, mux=0.
  - 6 DUP: stackOP=1, aluOP=5, mux=0.
  - 7 OVER: stackOP=1, aluOP=6, mux=0.
  - 8 DROP: stackOP=3. 9 SWAP: stackOP=5.
  - A BEQ tgt: stackOP=4, aluOP=7. B BEZ tgt: stackOP=4, aluOP=8.
  - C JMP tgt.
  - D PUSHS: push the 12-bit field sign-extended to 16 bits.
  - E illegal.
  - F HALT.
- States:
  - FETCH: assert `imem_req` with `imem_addr`=pc. On a sampled `imem_ack`, load IR and set pc←pc+1, then go to DECODE.
  - DECODE:
    - PUSHI → FETCH_IMM.
    - BEQ/BEZ → BRANCH.
    - JMP: pc←field[PC_WIDTH-1:0], then → FETCH.
    - NOP → FETCH.
    - HALT → HALT with fault=0.
    - E → HALT with fault=1.
    - Any other opcode → EXEC.
  - FETCH_IMM: same handshake as FETCH. On ack, latch the immediate register and set pc←pc+1, then → EXEC.
  - EXEC: drive the decoded controls for exactly one cycle, then → FETCH.
    - If HALT_ON_OVF=1, the opcode is ADD or SUB, and `Overflow`=1 at the closing edge, go to HALT with fault=2.
  - BRANCH: drive stackOP=4 plus aluOP for one cycle. Sample `ALU_out[0]` at the closing edge:
    - 1: pc←target.
    - 0: pc unchanged.
    - Either way → FETCH.
  - HALT: terminal until reset. All controls are 0, `imem_req`=0, `halted`=1.
- Output defaults: in every state other than EXEC/BRANCH, `stackOP`=0, `aluOP`=0, `mux_selector`=0. `immediate`=0 except in EXEC for PUSHI/PUSHS.
- Controls are decoded from registered state and IR only; there is no combinational path from `imem_rdata`.
- pc wraps from 2^PC_WIDTH−1 to 0 with no flag.

## Timing
- Reset values: state=FETCH, pc=0, IR=0, immediate register 0, `halted`=0, `fault`=0. All outputs are 0, including `imem_req`, which is gated low while `reset`=0.
- `imem_req` rises in the first cycle after reset deasserts.
- Handshake:
  - Once raised, `imem_req` stays high with a stable address until ack is sampled.
  - Ack may arrive in the same cycle as req (zero wait).
  - Ack while req=0 is ignored.
- Minimum latencies, from fetch issue to completion:
  - Single-word op: 3 cycles (FETCH, DECODE, EXEC).
  - PUSHI: 4 cycles.
  - Branch: 3 cycles.
  - JMP/NOP: 2 cycles.
  - Each wait cycle adds one.
- The stack commits at the rising edge that ends EXEC. `ALU_out` is combinational from the stack state, so it is valid during BRANCH.
- Reset asserted mid-handshake aborts immediately. A late ack after reset is ignored until a new req is raised.

## Structure
- `stack_isa_pkg` holds:
  - opcode constants;
  - stackOP, aluOP and mux codes, shared with the stack datapath;
  - fault codes;
  - state enum.
- One combinational sub-module, `stack_insn_decode`, maps opcode to {stackOP, aluOP, mux_selector, is_branch, is_two_word, illegal}. The top holds the FSM, pc, IR and immediate register.

## Test plan
- Zero-wait memory, program `1000 0005`, `D003`, `2000` → stackOP=1 with immediate 5, then stackOP=1 with immediate 3, then stackOP=2 with aluOP=0. Downstream top of stack is 8; pc=4.
- Program `D001`, `D001`, `A008`, with `ALU_out`=1 in BRANCH → next fetch address 0x008. Repeat with `ALU_out`=0 → next fetch address 0x003.
- Memory with 3 wait cycles per fetch → `imem_addr` held constant, no control pulse before ack, exactly one EXEC cycle per instruction.
- `DFFF` → immediate 0xFFFF (−1). `C7FF` → pc=0x7FF. pc starting at 0xFFF with a NOP → pc wraps to 0.
- `E000` → halted=1, fault=1, `imem_req` stays 0. `F000` → halted=1, fault=0.
- ADD with `Overflow`=1 and HALT_ON_OVF=1 → fault=2. Reset pulse during the FETCH_IMM wait → all outputs 0 and pc=0; fetch restarts at 0.
